// File: rtl/arbitro_rr_bus_4a1_16b_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_rr_bus_4a1_16b_pkg
//   Shared definitions for the 4:1 16-bit round-robin bus arbiter:
//     - requester count, index and data widths
//     - arbiter state codes
//     - the rotating-priority search (first requester at or after ptr)
//     - index -> one-hot grant conversion
// ---------------------------------------------------------------------------
package arbitro_rr_bus_4a1_16b_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int DATA_W  = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Result of the priority search: found=0 means nobody is requesting.
   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Search order is ptr, ptr+1, ptr+2, ptr+3 (mod NUM_REQ). The loop runs
   // from the lowest-priority slot upwards so the last hit written is the
   // highest-priority one.
   function automatic pick_t rr_search(input logic [NUM_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr);
      pick_t            res;
      logic [IDX_W-1:0] cand;
      res.found = 1'b0;
      res.idx   = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/arbitro_rr_bus_4a1_16b_mux.sv
// ---------------------------------------------------------------------------
// arbitro_rr_bus_4a1_16b_mux
//   Plain 4:1 multiplexer of 16-bit words (ungated; the arbiter applies the
//   valid gating on its own output).
// Ports:
//   sel      in   2   select index (0=a .. 3=d)
//   a,b,c,d  in   16  candidate words
//   y        out  16  selected word
// ---------------------------------------------------------------------------
module arbitro_rr_bus_4a1_16b_mux
   import arbitro_rr_bus_4a1_16b_pkg::*;
(
   input  logic [IDX_W-1:0]  sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y
);

   logic [DATA_W-1:0] words [NUM_REQ];

   assign words[0] = a;
   assign words[1] = b;
   assign words[2] = c;
   assign words[3] = d;

   assign y = words[sel];

endmodule

// File: rtl/arbitro_rr_bus_4a1_16b.sv
// ---------------------------------------------------------------------------
// arbitro_rr_bus_4a1_16b
//   Round-robin arbiter and sequencer for a shared 4:1 16-bit data bus.
//   One requester owns the bus at a time; its word is forwarded with a
//   VALID/READY handshake. A grant ends after MAX_BURST accepted beats or
//   when the owner drops its request, and the bus is re-arbitrated on that
//   same edge with the released requester at lowest priority.
// Parameters:
//   MAX_BURST  max beats per grant (>=1)
//   CNT_W      beat counter width = clog2(MAX_BURST), min 1
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset
//   req        in   4      level requests, bit i = requester i
//   a,b,c,d    in   16     data of requesters 0..3
//   out_ready  in   1      consumer accepts the current beat
//   gnt        out  4      registered one-hot grant (0 = no owner)
//   sel        out  2      registered index of the granted requester
//   out        out  16     selected data while out_valid, else 0
//   out_valid  out  1      combinational: owner present and still requesting
//   beat_cnt   out  CNT_W  beats completed in the current grant
// ---------------------------------------------------------------------------
module arbitro_rr_bus_4a1_16b
   import arbitro_rr_bus_4a1_16b_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 2
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic [DATA_W-1:0]  c,
   input  logic [DATA_W-1:0]  d,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   sel,
   output logic [DATA_W-1:0]  out,
   output logic               out_valid,
   output logic [CNT_W-1:0]   beat_cnt
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   state_t             state_reg, state_next;
   logic [NUM_REQ-1:0] gnt_reg,   gnt_next;
   logic [IDX_W-1:0]   sel_reg,   sel_next;
   logic [CNT_W-1:0]   cnt_reg,   cnt_next;
   logic [IDX_W-1:0]   ptr_reg,   ptr_next;

   logic               valid_c;
   logic               beat_c;
   logic               release_c;
   logic [IDX_W-1:0]   after_owner_c;
   logic [IDX_W-1:0]   search_ptr_c;
   pick_t              pick_c;
   logic [DATA_W-1:0]  mux_y;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign valid_c   = (state_reg == ST_GRANT) && req[sel_reg];
   assign beat_c    = valid_c && out_ready;
   // Dropping the request also releases; no beat can be counted then
   // because valid_c is already low.
   assign release_c = (beat_c && (cnt_reg == LAST_BEAT)) || !req[sel_reg];

   // ------------------------------------------------------------------
   // Single priority encoder: in IDLE it searches from the stored
   // pointer, in GRANT it searches from the slot after the current owner,
   // which is exactly the pointer value a release would store.
   // ------------------------------------------------------------------
   assign after_owner_c = sel_reg + IDX_W'(1);
   assign search_ptr_c  = (state_reg == ST_GRANT) ? after_owner_c : ptr_reg;
   assign pick_c        = rr_search(req, search_ptr_c);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= '0;
         sel_reg   <= '0;
         cnt_reg   <= '0;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;

      case (state_reg)
         ST_IDLE: begin
            if (pick_c.found) begin
               state_next = ST_GRANT;
               sel_next   = pick_c.idx;
               gnt_next   = idx_to_onehot(pick_c.idx);
               cnt_next   = '0;
            end
         end

         ST_GRANT: begin
            if (release_c) begin
               // Re-arbitrate on this same edge: no bubble between owners.
               ptr_next = after_owner_c;
               cnt_next = '0;
               if (pick_c.found) begin
                  sel_next = pick_c.idx;
                  gnt_next = idx_to_onehot(pick_c.idx);
               end else begin
                  state_next = ST_IDLE;
                  gnt_next   = '0;
               end
            end else if (beat_c) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = ST_IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Data path
   // ------------------------------------------------------------------
   arbitro_rr_bus_4a1_16b_mux u_mux (
      .sel (sel_reg),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (mux_y)
   );

   assign out       = valid_c ? mux_y : '0;
   assign out_valid = valid_c;
   assign gnt       = gnt_reg;
   assign sel       = sel_reg;
   assign beat_cnt  = cnt_reg;

endmodule

// File: tb/tb_arbitro_rr_bus_4a1_16b.sv
// ---------------------------------------------------------------------------
// tb_arbitro_rr_bus_4a1_16b
//   Directed scenarios plus a randomized run, all shadowed cycle by cycle
//   by a behavioural model (owner index, beats taken, priority pointer).
// ---------------------------------------------------------------------------
module tb_arbitro_rr_bus_4a1_16b;

   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] dw [4];
   logic        out_ready;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [15:0] out;
   logic        out_valid;
   logic [1:0]  beat_cnt;

   int compared   = 0;
   int mismatched = 0;

   // behavioural model state
   bit m_known = 0;
   int m_owner = -1;
   int m_beats = 0;
   int m_ptr   = 0;

   always #5 clk = ~clk;

   arbitro_rr_bus_4a1_16b #(.MAX_BURST(MB), .CNT_W(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .a         (dw[0]),
      .b         (dw[1]),
      .c         (dw[2]),
      .d         (dw[3]),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .beat_cnt  (beat_cnt)
   );

   // first requester at or after ptr in circular order, -1 if none
   function automatic int pick_m(input logic [3:0] r, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   // One clock cycle: check outputs against the model, then advance the
   // model with the inputs present at the edge.
   task automatic tick();
      logic [3:0]  e_gnt;
      logic        e_valid;
      logic [15:0] e_out;
      logic [1:0]  e_cnt;
      int          n_owner, n_beats, n_ptr;
      bit          beat;
      #1;
      if (m_known) begin
         e_gnt   = 4'b0000;
         e_valid = 1'b0;
         e_out   = 16'h0000;
         if (m_owner >= 0) begin
            e_gnt   = 4'(1 << m_owner);
            e_valid = req[m_owner];
            if (e_valid) e_out = dw[m_owner];
         end
         e_cnt = 2'(m_beats);
         compared += 4;
         if (gnt !== e_gnt) begin
            mismatched++;
            $display("FAIL model_gnt t=%0t got=%b want=%b", $time, gnt, e_gnt);
         end
         if (out_valid !== e_valid) begin
            mismatched++;
            $display("FAIL model_valid t=%0t got=%b want=%b", $time, out_valid, e_valid);
         end
         if (out !== e_out) begin
            mismatched++;
            $display("FAIL model_out t=%0t got=%h want=%h", $time, out, e_out);
         end
         if (beat_cnt !== e_cnt) begin
            mismatched++;
            $display("FAIL model_cnt t=%0t got=%0d want=%0d", $time, beat_cnt, e_cnt);
         end
         if (m_owner >= 0) begin
            compared++;
            if (sel !== 2'(m_owner)) begin
               mismatched++;
               $display("FAIL model_sel t=%0t got=%0d want=%0d", $time, sel, m_owner);
            end
         end
      end
      n_owner = m_owner;
      n_beats = m_beats;
      n_ptr   = m_ptr;
      if (!reset_n) begin
         n_owner = -1;
         n_beats = 0;
         n_ptr   = 0;
      end else if (m_known) begin
         if (m_owner < 0) begin
            n_owner = pick_m(req, m_ptr);
            n_beats = 0;
         end else begin
            beat = req[m_owner] && out_ready;
            if ((beat && m_beats == MB - 1) || !req[m_owner]) begin
               n_ptr   = (m_owner + 1) % 4;
               n_owner = pick_m(req, n_ptr);
               n_beats = 0;
            end else if (beat) begin
               n_beats = m_beats + 1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (!reset_n) m_known = 1;
      m_owner = n_owner;
      m_beats = n_beats;
      m_ptr   = n_ptr;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req       = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared += 4;
         if (gnt !== 4'b0000) begin mismatched++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
         if (sel !== 2'd0) begin mismatched++; $display("FAIL reset_sel got=%0d want=0", sel); end
         if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b want=0", out_valid); end
         if (out !== 16'h0) begin mismatched++; $display("FAIL reset_out got=%h want=0000", out); end
      end
      reset_n = 1'b1;
      tick();
      compared += 2;
      if (gnt !== 4'b0001) begin mismatched++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
      if (out !== dw[0]) begin mismatched++; $display("FAIL reset_first_out got=%h want=%h", out, dw[0]); end
   endtask

   task automatic test_rotation();
      logic [15:0] e;
      do_reset();
      req       = 4'hF;
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 32; k++) begin
         e = 16'(16'h1111 * ((k / 4) % 4 + 1));
         compared += 2;
         if (out !== e) begin mismatched++; $display("FAIL rotation_out beat=%0d got=%h want=%h", k, out, e); end
         if (gnt === 4'b0000) begin mismatched++; $display("FAIL rotation_gap beat=%0d got=%b want=nonzero", k, gnt); end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      req       = 4'b0100;
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         compared += 3;
         if (gnt !== 4'b0100) begin mismatched++; $display("FAIL single_gnt cyc=%0d got=%b want=0100", k, gnt); end
         if (out_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid cyc=%0d got=%b want=1", k, out_valid); end
         if (beat_cnt !== 2'(k % 4)) begin mismatched++; $display("FAIL single_cnt cyc=%0d got=%0d want=%0d", k, beat_cnt, k % 4); end
         tick();
      end
   endtask

   task automatic test_drop();
      do_reset();
      req       = 4'b0010;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      req = 4'b1000;
      #1;
      compared += 3;
      if (gnt !== 4'b0010) begin mismatched++; $display("FAIL drop_gnt_before got=%b want=0010", gnt); end
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL drop_valid got=%b want=0", out_valid); end
      if (beat_cnt !== 2'd2) begin mismatched++; $display("FAIL drop_cnt got=%0d want=2", beat_cnt); end
      tick();
      compared++;
      if (gnt !== 4'b1000) begin mismatched++; $display("FAIL drop_next_gnt got=%b want=1000", gnt); end
   endtask

   task automatic test_stall();
      do_reset();
      req       = 4'hF;
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         compared += 4;
         if (gnt !== 4'b0001) begin mismatched++; $display("FAIL stall_gnt cyc=%0d got=%b want=0001", k, gnt); end
         if (sel !== 2'd0) begin mismatched++; $display("FAIL stall_sel cyc=%0d got=%0d want=0", k, sel); end
         if (out !== dw[0]) begin mismatched++; $display("FAIL stall_out cyc=%0d got=%h want=%h", k, out, dw[0]); end
         if (beat_cnt !== 2'd1) begin mismatched++; $display("FAIL stall_cnt cyc=%0d got=%0d want=1", k, beat_cnt); end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         compared += 2;
         if (beat_cnt !== 2'(1 + k)) begin mismatched++; $display("FAIL resume_cnt beat=%0d got=%0d want=%0d", k, beat_cnt, 1 + k); end
         if (gnt !== 4'b0001) begin mismatched++; $display("FAIL resume_gnt beat=%0d got=%b want=0001", k, gnt); end
         tick();
      end
      compared += 2;
      if (gnt !== 4'b0010) begin mismatched++; $display("FAIL resume_rotate got=%b want=0010", gnt); end
      if (beat_cnt !== 2'd0) begin mismatched++; $display("FAIL resume_cnt_clear got=%0d want=0", beat_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req       = 4'b1000;
      out_ready = 1'b1;
      tick();
      tick();
      compared++;
      if (gnt !== 4'b1000) begin mismatched++; $display("FAIL midrst_owner got=%b want=1000", gnt); end
      reset_n = 1'b0;
      req     = 4'hF;
      tick();
      compared += 3;
      if (gnt !== 4'b0000) begin mismatched++; $display("FAIL midrst_gnt got=%b want=0000", gnt); end
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
      if (beat_cnt !== 2'd0) begin mismatched++; $display("FAIL midrst_cnt got=%0d want=0", beat_cnt); end
      reset_n = 1'b1;
      tick();
      compared++;
      if (gnt !== 4'b0001) begin mismatched++; $display("FAIL midrst_regrant got=%b want=0001", gnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         req       = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req = 4'hF;
         out_ready = ($urandom_range(0, 3) != 0);
         reset_n   = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < 4; i++) dw[i] = 16'($urandom);
         tick();
         compared++;
         if (!$onehot0(gnt)) begin mismatched++; $display("FAIL random_onehot cyc=%0d got=%b want=onehot0", k, gnt); end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = 4'h0;
      out_ready = 1'b0;
      dw[0] = 16'h1111;
      dw[1] = 16'h2222;
      dw[2] = 16'h3333;
      dw[3] = 16'h4444;
      test_reset();
      test_rotation();
      test_single();
      test_drop();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
